// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioner: FSM state encodings and parameter defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package input_cond_pkg;

    // Debounce FSM state encodings. The IDLE states hold a committed level.
    // The CHK states count toward committing the opposite level.
    localparam logic [1:0] IDLE_LOW  = 2'b00;
    localparam logic [1:0] CHK_HIGH  = 2'b01;
    localparam logic [1:0] IDLE_HIGH = 2'b10;
    localparam logic [1:0] CHK_LOW   = 2'b11;

    // Default build parameters
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_ff.sv
// N-deep 1-bit flop chain that brings an asynchronous input into the clk domain.
// Latency: SYNC_STAGES cycles from input sample to q.
// Backpressure: none; the chain samples every cycle.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the chain; reset clears every stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a bouncy button; emits a clean level plus one-cycle rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges after the first edge that samples the new level.
// Backpressure: none. fall_pulse exists only when INPUT_COND_FALL_PULSE_EN is defined; otherwise it is tied to 0.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic in_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          at_max;
    logic          commit_rise;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    // The count saturates at CNT_MAX, so the commit compare never needs to handle wrap.
    assign at_max      = (cnt == CNT_MAX);
    assign commit_rise = (state == CHK_HIGH) && s && at_max;

    // Debounce FSM. The counter counts consecutive samples that differ from the committed level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            in_level   <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= commit_rise;
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= CHK_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (at_max) begin
                        state    <= IDLE_HIGH;
                        cnt      <= '0;
                        in_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= CHK_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (at_max) begin
                        state    <= IDLE_LOW;
                        cnt      <= '0;
                        in_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef INPUT_COND_FALL_PULSE_EN
    logic commit_fall;
    assign commit_fall = (state == CHK_LOW) && !s && at_max;

    // One-cycle pulse on each committed fall. It uses the same compare that clears in_level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= commit_fall;
        end
    end
`else
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner, checked against a run-length debounce model.
// Latency: default parameters are used, so a commit is expected 5 edges after the first sampling edge.
// Backpressure: n/a.
module tb_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic in_level;
    logic rise_pulse;
    logic fall_pulse;

    int checks   = 0;
    int failures = 0;

    // Reference model: a delay line for the synchronizer and a count of consecutive disagreeing samples.
    logic hist [SS];
    logic m_lvl;
    logic m_rise;
    logic m_fall;
    int   m_run;

    // Observation bookkeeping
    int   edge_n = 0;
    int   rise_n = 0;
    int   fall_n = 0;
    int   last_rise_edge = -1;
    int   last_lvl_fall_edge = -1;
    logic prev_lvl = 1'b0;
    int   base;

    always #5 clk = ~clk;

    input_conditioner #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .in_level   (in_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        m_lvl  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_edge();
        logic s_used;
        if (reset) begin
            model_reset();
        end else begin
            s_used = hist[SS-1];
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = raw_in;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s_used != m_lvl) begin
                m_run++;
                if (m_run == DC) begin
                    m_lvl = s_used;
                    if (s_used) m_rise = 1'b1;
                    else        m_fall = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    function automatic logic exp_fall();
`ifdef INPUT_COND_FALL_PULSE_EN
        return m_fall;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string where);
        check({where, ".in_level"},   in_level,   m_lvl);
        check({where, ".rise_pulse"}, rise_pulse, m_rise);
        check({where, ".fall_pulse"}, fall_pulse, exp_fall());
    endtask

    // Drive raw_in, take one clock edge, then compare the outputs against the model.
    task automatic cycle(input logic r);
        raw_in = r;
        @(posedge clk);
        model_edge();
        #1;
        edge_n++;
        if (rise_pulse === 1'b1) begin
            rise_n++;
            last_rise_edge = edge_n;
        end
        if (fall_pulse === 1'b1) fall_n++;
        if (prev_lvl === 1'b1 && in_level === 1'b0) last_lvl_fall_edge = edge_n;
        prev_lvl = in_level;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b0;
    endtask

    // Directed steps first, then a randomized soak against the model.
    initial begin
        logic pat [9];
        logic v;
        int   len;

        raw_in = 1'b0;
        reset  = 1'b1;
        model_reset();
        #2;
        check_outputs("reset0");
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b0;

        // Held high from reset: commit at edge 5 with exactly one rise pulse
        rise_n = 0; fall_n = 0;
        base = edge_n;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check_int("hold_rise_count", rise_n, 1);
        check_int("hold_rise_latency", last_rise_edge - (base + 1), 5);
        check_int("hold_fall_count", fall_n, 0);

        // A 3-cycle pulse is rejected; a 4-cycle pulse is accepted once
        do_reset();
        rise_n = 0;
        for (int i = 0; i < 3; i++)  cycle(1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0);
        check_int("short_pulse_rises", rise_n, 0);
        for (int i = 0; i < 4; i++)  cycle(1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0);
        check_int("four_pulse_rises", rise_n, 1);

        // Bounce pattern: one rise, 5 edges after the final run of ones starts at index 5
        do_reset();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rise_n = 0;
        base = edge_n;
        for (int i = 0; i < 9; i++) cycle(pat[i]);
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check_int("bounce_rise_count", rise_n, 1);
        check_int("bounce_rise_edge", last_rise_edge - (base + 1), 10);

        // Committed high, then held low: the level falls 5 edges later
        fall_n = 0;
        last_lvl_fall_edge = -1;
        base = edge_n;
        for (int i = 0; i < 8; i++) cycle(1'b0);
        check_int("fall_latency", last_lvl_fall_edge - (base + 1), 5);
`ifdef INPUT_COND_FALL_PULSE_EN
        check_int("fall_pulse_count", fall_n, 1);
`else
        check_int("fall_pulse_count", fall_n, 0);
`endif

        // Reset asserted while checking a rise (cnt=2 after the fourth edge)
        do_reset();
        rise_n = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("midchk_reset");
        cycle(1'b1);
        cycle(1'b1);
        check_int("midchk_no_pulse", rise_n, 0);
        reset = 1'b0;
        base = edge_n;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check_int("post_reset_rise_count", rise_n, 1);
        check_int("post_reset_rise_latency", last_rise_edge - (base + 1), 5);

        // An asynchronous reset clears a committed-high level without waiting for an edge
        reset = 1'b1;
        model_reset();
        #1;
        check("async_clear.in_level", in_level, 1'b0);
        cycle(1'b0);
        reset = 1'b0;
        prev_lvl = 1'b0;

        // Randomized runs of mixed length with occasional asynchronous resets
        v = 1'b0;
        for (int k = 0; k < 300; k++) begin
            v = ~v;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) cycle(v);
            if ($urandom_range(0, 30) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_outputs("rand_reset");
                cycle(v);
                reset = 1'b0;
                prev_lvl = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the sequence FSM: takes an asynchronous, bouncy 1-bit input, synchronizes it into the `clk` domain, and debounces it. It emits a clean level plus a single-cycle rising-edge pulse. `rise_pulse` drives the sequence FSM's `in` port directly, so each accepted press advances that FSM by exactly one transition.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal 2..4.
- `DEBOUNCE_CYCLES`, default 4: consecutive equal synchronized samples needed to commit a level change; legal 2..255.
- `clk` in 1: single clock; all flops rise-edge.
- `reset` in 1: asynchronous, active-high; clears every flop immediately.
- `raw_in` in 1: asynchronous raw input (switch/button).
- `in_level` out 1: debounced level, registered.
- `rise_pulse` out 1: high for exactly one cycle on each committed 0->1 of `in_level`, registered.
- `fall_pulse` out 1: high for exactly one cycle on each committed 1->0 (see Configuration), registered.

## Operation
- `raw_in` passes through a `SYNC_STAGES`-deep flop chain; the last flop is `s`. Only `s` is used downstream.
- Counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide, unsigned. It is bounded by `DEBOUNCE_CYCLES-1` and never wraps.
- The FSM has four states, 2-bit encoded:
  - `IDLE_LOW` = 00
  - `CHK_HIGH` = 01
  - `IDLE_HIGH` = 10
  - `CHK_LOW` = 11
- `IDLE_LOW`: if `s`=1, go to `CHK_HIGH` with `cnt`=1; else stay.
- `CHK_HIGH`:
  - `s`=0: go to `IDLE_LOW`, `cnt`=0. The glitch is rejected with no output change.
  - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to `IDLE_HIGH`, `in_level`<=1, `rise_pulse`<=1, `cnt`=0.
  - `s`=1 otherwise: `cnt`++.
- `IDLE_HIGH` and `CHK_LOW` mirror the above with polarities swapped. Committing a fall sets `in_level`<=0 and `fall_pulse`<=1 (if enabled).
- `rise_pulse` and `fall_pulse` deassert on the cycle after assertion and are never high together.
- `in_level` changes only on commit edges.

## Timing
- Reset values:
  - state = `IDLE_LOW`
  - `cnt` = 0
  - all synchronizer flops = 0
  - `in_level` = 0, `rise_pulse` = 0, `fall_pulse` = 0
- Latency: let E0 be the first edge that samples `raw_in`=1. `in_level` and `rise_pulse` go high after edge E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1. With defaults this is edge E5. Falls have the same latency.
- Acceptance threshold: a `raw_in` pulse is accepted only if it is stable for at least `DEBOUNCE_CYCLES` consecutive edges. Shorter pulses produce no output activity.
- Reset mid-check: the pending transition is discarded and no pulse is emitted.
- `raw_in` held high across reset release: treated as a fresh rise. `rise_pulse` fires at the normal latency after the first post-reset sampling edge.
- Continuous bouncing faster than `DEBOUNCE_CYCLES`: the FSM oscillates between an IDLE state and its CHK state. Outputs hold.

## Configuration
- Macro: `INPUT_COND_FALL_PULSE_EN`.
- Defined: the `fall_pulse` flop exists and asserts for one cycle when `CHK_LOW` commits to `IDLE_LOW`.
- Undefined: `fall_pulse` is tied to constant 0 and no flop is instantiated. The FSM and `in_level` behave identically in both builds.

## Structure
- Shared package `input_cond_pkg` holds:
  - the four state encodings as 2-bit localparams;
  - the default values of `SYNC_STAGES` and `DEBOUNCE_CYCLES`.
- Sub-module `sync_ff`: parameterized `SYNC_STAGES`-deep 1-bit synchronizer, async active-high reset to 0. It is instantiated once.
- The FSM, counter and output registers live in `input_conditioner`.

## Test plan
- Reset then `raw_in`=1 held, defaults: `in_level` rises after edge 5 (counting from the first sampling edge as edge 0). `rise_pulse` is high exactly one cycle at the same time. `fall_pulse` stays 0.
- `raw_in` high for 3 cycles then low: `in_level` and `rise_pulse` stay 0 throughout. A 4-cycle pulse is accepted with `rise_pulse` exactly once.
- Bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle): exactly one `rise_pulse`, issued 5 edges after the final run of four 1s begins.
- Committed high, then `raw_in`=0 held: `in_level` falls 5 edges later. With `INPUT_COND_FALL_PULSE_EN` defined, `fall_pulse` is high one cycle; with it undefined, `fall_pulse` stays 0.
- `reset` asserted during `CHK_HIGH` (`cnt`=2): all outputs are 0 immediately and no pulse occurs. After release with `raw_in` held high, `rise_pulse` fires 5 edges after the first sampling edge.
